// File: rtl/alu_pkg.sv
// Shared definitions for the Mic-1 ALU: widths, control-word layout and the
// named control encodings used by the microcode.
package alu_pkg;

  localparam int NBITS       = 16;
  localparam int ALU_CONTROL = 6;

  // Control word layout, MSB first: {F0,F1,ENA,ENB,INVA,INC}
  typedef struct packed {
    logic f0;
    logic f1;
    logic ena;
    logic enb;
    logic inva;
    logic inc;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FN_AND  = 2'b00,
    FN_OR   = 2'b01,
    FN_NOTB = 2'b10,
    FN_ADD  = 2'b11
  } alu_fn_t;

  localparam logic [ALU_CONTROL-1:0] CTRL_A         = 6'h18;
  localparam logic [ALU_CONTROL-1:0] CTRL_B         = 6'h14;
  localparam logic [ALU_CONTROL-1:0] CTRL_NOTA      = 6'h1A;
  localparam logic [ALU_CONTROL-1:0] CTRL_NOTB      = 6'h2C;
  localparam logic [ALU_CONTROL-1:0] CTRL_APLUSB    = 6'h3C;
  localparam logic [ALU_CONTROL-1:0] CTRL_APLUSBINC = 6'h3D;
  localparam logic [ALU_CONTROL-1:0] CTRL_INCA      = 6'h39;
  localparam logic [ALU_CONTROL-1:0] CTRL_INCB      = 6'h35;
  localparam logic [ALU_CONTROL-1:0] CTRL_BMINUSA   = 6'h3F;
  localparam logic [ALU_CONTROL-1:0] CTRL_DECB      = 6'h36;
  localparam logic [ALU_CONTROL-1:0] CTRL_MINUSA    = 6'h3B;
  localparam logic [ALU_CONTROL-1:0] CTRL_AANDB     = 6'h0C;
  localparam logic [ALU_CONTROL-1:0] CTRL_AORB      = 6'h1C;
  localparam logic [ALU_CONTROL-1:0] CTRL_ZERO      = 6'h10;
  localparam logic [ALU_CONTROL-1:0] CTRL_ONE       = 6'h31;
  localparam logic [ALU_CONTROL-1:0] CTRL_MINUSONE  = 6'h32;

endpackage

// File: rtl/alu_adder.sv
// Ripple-carry adder with carry-in; the final carry out of the MSB is never
// needed by the datapath, so the chain stops at the top sum bit.
module alu_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi] = x[gi] ^ y[gi] ^ carry[gi];
    if (gi < W - 1) begin : g_carry
      assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  end

endmodule

// File: rtl/alu.sv
// Mic-1 datapath ALU: combinational result and N/Z flags, plus the N/Z
// registers sampled each cycle for the microsequencer's conditional branches.
module alu
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBITS-1:0]       a,
  input  logic [NBITS-1:0]       b,
  input  logic [ALU_CONTROL-1:0] ctrl,
  output logic [NBITS-1:0]       c,
  output logic                   n,
  output logic                   z,
  output logic                   n_q,
  output logic                   z_q
);

  alu_ctrl_t        cw;
  alu_fn_t          fn;
  logic [NBITS-1:0] ea;
  logic [NBITS-1:0] eb;
  logic [NBITS-1:0] ai;
  logic [NBITS-1:0] sum;

  assign cw = alu_ctrl_t'(ctrl);
  assign fn = alu_fn_t'({cw.f0, cw.f1});

  // Inversion follows the enable, so ENA=0 with INVA=1 gives all ones.
  assign ea = cw.ena ? a : '0;
  assign eb = cw.enb ? b : '0;
  assign ai = cw.inva ? ~ea : ea;

  alu_adder #(.W(NBITS)) u_adder (
    .x   (ai),
    .y   (eb),
    .cin (cw.inc),
    .sum (sum)
  );

  always_comb begin
    c = '0;
    unique case (fn)
      FN_AND:  c = ai & eb;
      FN_OR:   c = ai | eb;
      FN_NOTB: c = ~eb;
      FN_ADD:  c = sum;
      default: c = '0;
    endcase
  end

  assign n = c[NBITS-1];
  assign z = (c == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      n_q <= n;
      z_q <= z;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed microcode encodings, flag register
// sequencing and randomized operands/control words against a reference model.
module tb_alu;
  import alu_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [NBITS-1:0]       a;
  logic [NBITS-1:0]       b;
  logic [ALU_CONTROL-1:0] ctrl;
  logic [NBITS-1:0]       c;
  logic                   n;
  logic                   z;
  logic                   n_q;
  logic                   z_q;

  int total = 0;
  int bad   = 0;

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .ctrl (ctrl),
    .c    (c),
    .n    (n),
    .z    (z),
    .n_q  (n_q),
    .z_q  (z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: operands as plain integers, complement as (2^16-1)-x,
  // addition reduced modulo 2^16.
  function automatic int ref_c(input int av, input int bv, input logic [5:0] cw);
    int ea, eb, ai, res;
    ea = cw[3] ? av : 0;
    eb = cw[2] ? bv : 0;
    ai = cw[1] ? (65535 - ea) : ea;
    case (cw[5:4])
      2'b00:   res = ai & eb;
      2'b01:   res = ai | eb;
      2'b10:   res = 65535 - eb;
      default: res = (ai + eb + (cw[0] ? 1 : 0)) % 65536;
    endcase
    return res;
  endfunction

  typedef struct {
    logic [5:0]  cw;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int  e;
    bit  en, ez;

    vecs[0]  = '{CTRL_A,         16'hCDCD, "A"};
    vecs[1]  = '{CTRL_B,         16'hABAB, "B"};
    vecs[2]  = '{CTRL_NOTA,      16'h3232, "NOTA"};
    vecs[3]  = '{CTRL_NOTB,      16'h5454, "NOTB"};
    vecs[4]  = '{CTRL_APLUSB,    16'h7978, "APLUSB"};
    vecs[5]  = '{CTRL_APLUSBINC, 16'h7979, "APLUSBINC"};
    vecs[6]  = '{CTRL_INCA,      16'hCDCE, "INCA"};
    vecs[7]  = '{CTRL_INCB,      16'hABAC, "INCB"};
    vecs[8]  = '{CTRL_BMINUSA,   16'hDDDE, "BMINUSA"};
    vecs[9]  = '{CTRL_DECB,      16'hABAA, "DECB"};
    vecs[10] = '{CTRL_MINUSA,    16'h3233, "MINUSA"};
    vecs[11] = '{CTRL_AANDB,     16'h8989, "AANDB"};
    vecs[12] = '{CTRL_AORB,      16'hEFEF, "AORB"};
    vecs[13] = '{CTRL_ZERO,      16'h0000, "ZERO"};
    vecs[14] = '{CTRL_ONE,       16'h0001, "ONE"};
    vecs[15] = '{CTRL_MINUSONE,  16'hFFFF, "MINUSONE"};

    rst = 1'b1; a = 16'hCDCD; b = 16'hABAB; ctrl = CTRL_MINUSONE;

    // Reset holds flags low for two edges even though n=1 combinationally.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_n_q", n_q, 0);
      check("rst_z_q", z_q, 0);
      $display("reset cycle %0d: n_q=%0b z_q=%0b c=%h", i, n_q, z_q, c);
    end
    check("rst_c_live", c, 16'hFFFF);

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rel_n_q", n_q, 1);
    check("rel_z_q", z_q, 0);
    $display("release: n_q=%0b z_q=%0b", n_q, z_q);

    @(negedge clk); ctrl = CTRL_ZERO;
    @(posedge clk); #1;
    check("zero_n_q", n_q, 0);
    check("zero_z_q", z_q, 1);
    $display("ZERO: n_q=%0b z_q=%0b", n_q, z_q);

    // Directed control encodings with a=CDCD, b=ABAB.
    foreach (vecs[i]) begin
      @(negedge clk);
      ctrl = vecs[i].cw;
      #1;
      check({vecs[i].name, "_c"}, c, vecs[i].exp);
      check({vecs[i].name, "_n"}, n, vecs[i].exp[15]);
      check({vecs[i].name, "_z"}, z, vecs[i].exp == 16'h0);
      $display("%s ctrl=%h c=%h n=%0b z=%0b", vecs[i].name, ctrl, c, n, z);
    end

    // Zero wrap on addition.
    @(negedge clk); a = 16'h0001; b = 16'hFFFF; ctrl = CTRL_APLUSB;
    #1;
    check("wrap_c", c, 16'h0000);
    check("wrap_z", z, 1);
    @(posedge clk); #1;
    check("wrap_z_q", z_q, 1);
    check("wrap_n_q", n_q, 0);
    $display("wrap: c=%h z=%0b z_q=%0b", c, z, z_q);

    // Random operands, control words and occasional reset.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a    = 16'($urandom);
      b    = 16'($urandom);
      ctrl = 6'($urandom);
      rst  = ($urandom_range(0, 15) == 0);
      #1;
      e  = ref_c(int'(a), int'(b), ctrl);
      en = (e >= 32768);
      ez = (e == 0);
      check("rnd_c", c, e);
      check("rnd_n", n, en);
      check("rnd_z", z, ez);
      @(posedge clk); #1;
      check("rnd_n_q", n_q, rst ? 1'b0 : en);
      check("rnd_z_q", z_q, rst ? 1'b0 : ez);
      $display("rnd %0d: a=%h b=%h ctrl=%h rst=%0b c=%h exp=%h n_q=%0b z_q=%0b",
               i, a, b, ctrl, rst, c, 16'(e), n_q, z_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Mic-1-style datapath ALU: 6-bit control word selects one of four functions (AND, OR, NOT B, ADD) on two NBITS operands.
- Operand A can be enabled, inverted and given a carry-in; operand B can be enabled.
- Result c is combinational and drives the datapath shifter/C-bus.
- n/z are combinational flags.
- n_q/z_q are the clocked N/Z flag registers consumed by the microsequencer for conditional branches.

Parameters:
- NBITS, 16, operand/result width (taken from the shared package).
- ALU_CONTROL, 6, control word width (taken from the shared package).

Ports:
- clk  in  1  system clock; flags sampled on rising edge.
- rst  in  1  synchronous active-high reset.
- a  in  NBITS  operand A (H register side).
- b  in  NBITS  operand B (B-bus side).
- ctrl  in  ALU_CONTROL  {F0,F1,ENA,ENB,INVA,INC}; ctrl[5]=F0 … ctrl[0]=INC.
- c  out  NBITS  combinational result.
- n  out  1  combinational negative flag = c[NBITS-1].
- z  out  1  combinational zero flag = (c == 0).
- n_q  out  1  registered N flag.
- z_q  out  1  registered Z flag.

Behaviour:
- Operand gating:
  - ea = ENA ? a : 0.
  - eb = ENB ? b : 0.
  - ai = INVA ? ~ea : ea. Inversion is applied after the enable, so ENA=0 with INVA=1 yields all ones.
- Function select {F0,F1}:
  - 00: c = ai & eb.
  - 01: c = ai | eb.
  - 10: c = ~eb.
  - 11: c = ai + eb + INC, truncated to NBITS; carry out is discarded.
- INC affects only the ADD function (11); it is ignored for 00/01/10.
- c, n and z are purely combinational with zero-cycle latency and no dependence on clk or rst.
- Every 6-bit ctrl value is legal and follows the rules above; there is no X output and no illegal-code trap.
- Registered flags:
  - On each rising clk edge: n_q <= n, z_q <= z.
  - If rst=1 at the edge: n_q <= 0, z_q <= 0. rst has priority over the flag update.
  - Flags update every cycle; there is no separate enable.
  - Reset asserted mid-operation affects only n_q/z_q; c, n and z keep following the inputs.
- Arithmetic is unsigned-modulo 2^NBITS; n interprets c as two's complement.

Decomposition:
- Shared package (definitions.svh) holds:
  - NBITS and ALU_CONTROL.
  - Named control encodings: A=18h, B=14h, NOTA=1Ah, NOTB=2Ch, APLUSB=3Ch, APLUSBINC=3Dh, INCA=39h, INCB=35h, BMINUSA=3Fh, DECB=36h, MINUSA=3Bh, AANDB=0Ch, AORB=1Ch, ZERO=10h, ONE=31h, MINUSONE=32h.
- Decoding of ctrl into F0/F1/ENA/ENB/INVA/INC is done inside alu.
- One sub-module is natural: alu_adder (NBITS ripple/behavioural adder with carry-in, carry-out unused).

Test Plan:
- Pass-through and inversion, a=CDCDh, b=ABABh:
  - A -> c=CDCDh, n=1, z=0.
  - B -> ABABh.
  - NOTA -> 3232h, n=0.
  - NOTB -> 5454h.
- Add family, same operands:
  - APLUSB -> 7978h (carry dropped).
  - APLUSBINC -> 7979h.
  - INCA -> CDCEh.
  - INCB -> ABACh.
- Subtract family, same operands:
  - BMINUSA -> DDDEh, n=1.
  - DECB -> ABAAh.
  - MINUSA -> 3233h.
- Logic and constants, same operands:
  - AANDB -> 8989h.
  - AORB -> EFEFh.
  - ZERO -> 0000h, z=1, n=0.
  - ONE -> 0001h.
  - MINUSONE -> FFFFh, n=1.
- Registered flags:
  - rst=1 for 2 cycles with ctrl=MINUSONE -> n_q=0, z_q=0.
  - Release rst -> next edge n_q=1, z_q=0.
  - ctrl=ZERO -> next edge n_q=0, z_q=1.
- Zero wrap: a=0001h, b=FFFFh, APLUSB -> c=0000h, z=1; the registered z_q=1 after one edge.
